// File: rtl/rsa_pkg.sv
// rsa_pkg: shared definitions for the RSA decryption controller.
//   - rsa_state_e   : controller FSM states
//   - RSA_WIDTH_DEF : default prime width
//   - NUM_MSG_DEF   : default ciphertexts per burst
//   - EXP_LEN_DEF   : default private-exponent length (2*WIDTH)
//   - exp_len()     : exponent length for a given prime width
package rsa_pkg;

  localparam int RSA_WIDTH_DEF = 4;
  localparam int NUM_MSG_DEF   = 8;
  localparam int EXP_LEN_DEF   = 2 * RSA_WIDTH_DEF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    KEY  = 3'd2,
    EXP  = 3'd3,
    OUT  = 3'd4
  } rsa_state_e;

  function automatic int exp_len(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/RSA_IP.sv
// RSA_IP: combinational RSA key generation.
// Ports:
//   IN_P, IN_Q : WIDTH-bit primes
//   IN_E       : 2*WIDTH-bit public exponent, coprime to phi = (P-1)(Q-1)
//   OUT_N      : modulus P*Q
//   OUT_D      : smallest positive D with (D*E) mod phi = 1 (0 if none exists)
module RSA_IP #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]   IN_P,
  input  logic [WIDTH-1:0]   IN_Q,
  input  logic [2*WIDTH-1:0] IN_E,
  output logic [2*WIDTH-1:0] OUT_N,
  output logic [2*WIDTH-1:0] OUT_D
);

  localparam int DW       = 2 * WIDTH;
  localparam int CAND_MAX = (32'sd1 <<< DW) - 32'sd1;
  localparam logic [2*DW-1:0] ONE_W = (2*DW)'(32'd1);
  localparam logic [DW-1:0]   ONE_D = DW'(32'd1);

  logic [DW-1:0]   phi_s;
  logic [DW-1:0]   cand_s;
  logic [2*DW-1:0] prod_s;
  logic [DW-1:0]   d_s;

  // Exhaustive inverse search, scanned downward so the smallest match is the one kept.
  always_comb begin
    phi_s  = ({{WIDTH{1'b0}}, IN_P} - ONE_D) * ({{WIDTH{1'b0}}, IN_Q} - ONE_D);
    d_s    = {DW{1'b0}};
    cand_s = {DW{1'b0}};
    prod_s = {(2*DW){1'b0}};
    for (int i = CAND_MAX; i >= 1; i--) begin
      cand_s = DW'(i);
      prod_s = {{DW{1'b0}}, cand_s} * {{DW{1'b0}}, IN_E};
      if ((phi_s != {DW{1'b0}}) && ((prod_s % {{DW{1'b0}}, phi_s}) == ONE_W)) begin
        d_s = cand_s;
      end else begin
        d_s = d_s;
      end
    end
  end

  assign OUT_N = {{WIDTH{1'b0}}, IN_P} * {{WIDTH{1'b0}}, IN_Q};
  assign OUT_D = d_s;

endmodule

// File: rtl/rsa_modmul.sv
// rsa_modmul: combinational modular multiply, m = (a*b) mod n.
// Ports:
//   a, b : 2*WIDTH-bit operands (expected < n)
//   n    : 2*WIDTH-bit modulus; n = 0 yields m = 0
//   m    : 2*WIDTH-bit result
module rsa_modmul #(
  parameter int WIDTH = 4
) (
  input  logic [2*WIDTH-1:0] a,
  input  logic [2*WIDTH-1:0] b,
  input  logic [2*WIDTH-1:0] n,
  output logic [2*WIDTH-1:0] m
);

  logic [4*WIDTH-1:0] prod_s;

  // Full-width product followed by reduction; the remainder is < n so it fits in 2*WIDTH bits.
  always_comb begin
    prod_s = {{(2*WIDTH){1'b0}}, a} * {{(2*WIDTH){1'b0}}, b};
    if (n == {(2*WIDTH){1'b0}}) begin
      m = {(2*WIDTH){1'b0}};
    end else begin
      m = (2*WIDTH)'(prod_s % {{(2*WIDTH){1'b0}}, n});
    end
  end

endmodule

// File: rtl/rsa_decrypt_ctrl.sv
// rsa_decrypt_ctrl: burst RSA decryption controller.
// Accepts one key set (P, Q, E) plus NUM_MSG ciphertexts, derives N/D through
// RSA_IP, decrypts each ciphertext by MSB-first square-and-multiply (one
// exponent bit per cycle) and streams the plaintexts out as a contiguous burst.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   in_valid        : input beat qualifier
//   in_p, in_q, in_e: key, sampled on the first beat only
//   in_c            : ciphertext, sampled on every beat
//   out_valid       : plaintext beat qualifier
//   out_m           : plaintext, 0 whenever out_valid is 0
module rsa_decrypt_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH   = RSA_WIDTH_DEF,
  parameter int NUM_MSG = NUM_MSG_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_p,
  input  logic [WIDTH-1:0]   in_q,
  input  logic [2*WIDTH-1:0] in_e,
  input  logic [2*WIDTH-1:0] in_c,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] out_m
);

  localparam int DW       = 2 * WIDTH;
  localparam int EXP_BITS = exp_len(WIDTH);
  localparam int IDX_W    = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
  localparam int BIT_W    = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MSG - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'd1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(32'd0);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(EXP_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(32'd1);
  localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(32'd0);
  localparam logic [DW-1:0]    DW_ONE   = DW'(32'd1);
  localparam logic [DW-1:0]    DW_ZERO  = DW'(32'd0);

  rsa_state_e state_r, state_s;

  logic [WIDTH-1:0] p_r, q_r;
  logic [DW-1:0]    e_r, n_r, d_r;
  logic [DW-1:0]    ip_n_s, ip_d_s;
  logic [DW-1:0]    c_buf_r [NUM_MSG];
  logic [DW-1:0]    m_buf_r [NUM_MSG];
  logic [IDX_W-1:0] beat_cnt_r, msg_idx_r, out_idx_r, out_sel_s;
  logic [BIT_W-1:0] bit_idx_r;
  logic [DW-1:0]    r_r, sq_s, mul_s, r_nx_s, out_data_s;
  logic             out_valid_r;
  logic [DW-1:0]    out_m_r;

  logic last_beat_s, last_bit_s, last_msg_s, last_out_s;

  assign last_beat_s = (beat_cnt_r == LAST_IDX);
  assign last_bit_s  = (bit_idx_r == BIT_ZERO);
  assign last_msg_s  = (msg_idx_r == LAST_IDX);
  assign last_out_s  = (out_idx_r == LAST_IDX);

  RSA_IP #(.WIDTH(WIDTH)) u_rsa_ip (
    .IN_P  (p_r),
    .IN_Q  (q_r),
    .IN_E  (e_r),
    .OUT_N (ip_n_s),
    .OUT_D (ip_d_s)
  );

  // Square, then multiply by the current ciphertext, chained in one cycle.
  rsa_modmul #(.WIDTH(WIDTH)) u_square (
    .a (r_r),
    .b (r_r),
    .n (n_r),
    .m (sq_s)
  );

  rsa_modmul #(.WIDTH(WIDTH)) u_multiply (
    .a (sq_s),
    .b (c_buf_r[msg_idx_r]),
    .n (n_r),
    .m (mul_s)
  );

  // Keep the multiplied result only when the current exponent bit is set.
  always_comb begin
    if (d_r[bit_idx_r]) begin
      r_nx_s = mul_s;
    end else begin
      r_nx_s = sq_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = LOAD;
        else          state_s = IDLE;
      end
      LOAD: begin
        if (!in_valid)       state_s = IDLE;
        else if (last_beat_s) state_s = KEY;
        else                 state_s = LOAD;
      end
      KEY: state_s = EXP;
      EXP: begin
        if (last_bit_s && last_msg_s) state_s = OUT;
        else                          state_s = EXP;
      end
      OUT: begin
        if (last_out_s) state_s = IDLE;
        else            state_s = OUT;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output buffer select: index 0 on entry to OUT, then the following slot.
  // The bypass covers a plaintext being written on the same edge it is first needed.
  always_comb begin
    if (state_r == OUT) begin
      out_sel_s = out_idx_r + IDX_ONE;
    end else begin
      out_sel_s = IDX_ZERO;
    end
    if ((state_r == EXP) && last_bit_s && (msg_idx_r == out_sel_s)) begin
      out_data_s = r_nx_s;
    end else begin
      out_data_s = m_buf_r[out_sel_s];
    end
  end

  // Capture, key registration, exponentiation and output-index datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_r        <= {WIDTH{1'b0}};
      q_r        <= {WIDTH{1'b0}};
      e_r        <= DW_ZERO;
      n_r        <= DW_ZERO;
      d_r        <= DW_ZERO;
      r_r        <= DW_ZERO;
      beat_cnt_r <= IDX_ZERO;
      msg_idx_r  <= IDX_ZERO;
      out_idx_r  <= IDX_ZERO;
      bit_idx_r  <= BIT_ZERO;
      for (int i = 0; i < NUM_MSG; i++) begin
        c_buf_r[i] <= DW_ZERO;
        m_buf_r[i] <= DW_ZERO;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            p_r        <= in_p;
            q_r        <= in_q;
            e_r        <= in_e;
            c_buf_r[0] <= in_c;
            beat_cnt_r <= IDX_ONE;
          end else begin
            beat_cnt_r <= IDX_ZERO;
          end
        end
        LOAD: begin
          if (in_valid) begin
            c_buf_r[beat_cnt_r] <= in_c;
            beat_cnt_r          <= beat_cnt_r + IDX_ONE;
          end else begin
            beat_cnt_r <= IDX_ZERO;
          end
        end
        KEY: begin
          n_r       <= ip_n_s;
          d_r       <= ip_d_s;
          r_r       <= DW_ONE;
          bit_idx_r <= LAST_BIT;
          msg_idx_r <= IDX_ZERO;
        end
        EXP: begin
          if (last_bit_s) begin
            m_buf_r[msg_idx_r] <= r_nx_s;
            r_r                <= DW_ONE;
            bit_idx_r          <= LAST_BIT;
            msg_idx_r          <= msg_idx_r + IDX_ONE;
            out_idx_r          <= IDX_ZERO;
          end else begin
            r_r       <= r_nx_s;
            bit_idx_r <= bit_idx_r - BIT_ONE;
          end
        end
        OUT: begin
          out_idx_r <= out_idx_r + IDX_ONE;
        end
        default: begin
          beat_cnt_r <= IDX_ZERO;
        end
      endcase
    end
  end

  // Registered outputs, driven one cycle ahead from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_m_r     <= DW_ZERO;
    end else if (state_s == OUT) begin
      out_valid_r <= 1'b1;
      out_m_r     <= out_data_s;
    end else begin
      out_valid_r <= 1'b0;
      out_m_r     <= DW_ZERO;
    end
  end

  assign out_valid = out_valid_r;
  assign out_m     = out_m_r;

endmodule

// File: tb/tb_rsa_decrypt_ctrl.sv
// tb_rsa_decrypt_ctrl: directed self-checking bench for rsa_decrypt_ctrl
// (WIDTH = 4, NUM_MSG = 8). Expected plaintexts are hand-computed.
module tb_rsa_decrypt_ctrl;

  typedef logic [7:0] vec_t [8];

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_p, in_q;
  logic [7:0] in_e, in_c;
  logic       out_valid;
  logic [7:0] out_m;

  int cyc;
  int n_cmp;
  int n_bad;

  // 31^7 mod 33 = 4
  vec_t c_a = '{default: 8'd31};
  vec_t m_a = '{default: 8'd4};
  // N=35, D=5: 32->2, 0->0, 1->1, 34->34
  vec_t c_b = '{8'd32, 8'd0, 8'd1, 8'd34, 8'd32, 8'd1, 8'd0, 8'd34};
  vec_t m_b = '{8'd2, 8'd0, 8'd1, 8'd34, 8'd2, 8'd1, 8'd0, 8'd34};

  rsa_decrypt_ctrl #(.WIDTH(4), .NUM_MSG(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_p      (in_p),
    .in_q      (in_q),
    .in_e      (in_e),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_m     (out_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    cyc = cyc + 1;
  endtask

  // Drives nbeats beats starting at the current cycle; key fields carry junk after beat 0.
  task automatic drive_burst(input logic [3:0] p, input logic [3:0] q, input logic [7:0] e,
                             input vec_t c, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      in_valid = 1'b1;
      in_p     = (i == 0) ? p : 4'hF;
      in_q     = (i == 0) ? q : 4'hE;
      in_e     = (i == 0) ? e : 8'hFF;
      in_c     = c[i];
      tick();
    end
    in_valid = 1'b0;
    in_c     = 8'd0;
  endtask

  // Waits for the first out_valid, then samples 8 consecutive cycles.
  task automatic capture(input bit pulse, output int first_cyc, output vec_t got, output int nvalid);
    first_cyc = -1;
    nvalid    = 0;
    got       = '{default: 8'd0};
    for (int k = 0; k < 120 && first_cyc < 0; k++) begin
      if (out_valid === 1'b1) begin
        first_cyc = cyc;
      end else begin
        tick();
        if (pulse) begin
          in_valid = cyc[0];
          in_c     = 8'(cyc * 7);
          in_p     = 4'hF;
        end
      end
    end
    if (first_cyc >= 0) begin
      for (int k = 0; k < 8; k++) begin
        if (k > 0) begin
          tick();
          if (pulse) begin
            in_valid = cyc[0];
            in_c     = 8'(cyc * 3);
          end
        end
        if (out_valid === 1'b1) begin
          got[k] = out_m;
          nvalid = nvalid + 1;
        end
      end
    end
    in_valid = 1'b0;
    in_c     = 8'd0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_cmp++;
    if (out_m !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_out_m: got %0d expected 0", out_m);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_key();
    int t0, first, nv;
    vec_t got;
    t0 = cyc;
    drive_burst(4'd3, 4'd11, 8'd3, c_a, 8);
    capture(1'b0, first, got, nv);
    n_cmp++;
    if (first - t0 !== 73) begin
      n_bad++;
      $display("FAIL single_latency: got %0d expected 73", first - t0);
    end
    n_cmp++;
    if (nv !== 8) begin
      n_bad++;
      $display("FAIL single_valid_count: got %0d expected 8", nv);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (got[k] !== m_a[k]) begin
        n_bad++;
        $display("FAIL single_m[%0d]: got %0d expected %0d", k, got[k], m_a[k]);
      end
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_m !== 8'd0) begin
      n_bad++;
      $display("FAIL single_after: got valid=%b m=%0d expected valid=0 m=0", out_valid, out_m);
    end
  endtask

  task automatic test_mixed_cipher();
    int t0, first, nv;
    vec_t got;
    t0 = cyc;
    drive_burst(4'd5, 4'd7, 8'd5, c_b, 8);
    capture(1'b0, first, got, nv);
    n_cmp++;
    if (first - t0 !== 73 || nv !== 8) begin
      n_bad++;
      $display("FAIL mixed_timing: got latency=%0d valid=%0d expected 73/8", first - t0, nv);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (got[k] !== m_b[k]) begin
        n_bad++;
        $display("FAIL mixed_m[%0d]: got %0d expected %0d", k, got[k], m_b[k]);
      end
    end
    tick();
  endtask

  task automatic test_abort();
    int t0, first, nv;
    vec_t got;
    drive_burst(4'd5, 4'd7, 8'd5, c_b, 3);
    // Abort observed at this cycle; the legal burst starts on the next one.
    tick();
    t0 = cyc;
    drive_burst(4'd3, 4'd11, 8'd3, c_a, 8);
    capture(1'b0, first, got, nv);
    n_cmp++;
    if (first - t0 !== 73) begin
      n_bad++;
      $display("FAIL abort_latency: got %0d expected 73 (spurious or missing output)", first - t0);
    end
    n_cmp++;
    if (nv !== 8) begin
      n_bad++;
      $display("FAIL abort_valid_count: got %0d expected 8", nv);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (got[k] !== m_a[k]) begin
        n_bad++;
        $display("FAIL abort_m[%0d]: got %0d expected %0d", k, got[k], m_a[k]);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_exp();
    int t0, first, nv, seen;
    vec_t got;
    drive_burst(4'd3, 4'd11, 8'd3, c_a, 8);
    for (int k = 0; k < 20; k++) tick();
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_m !== 8'd0) begin
      n_bad++;
      $display("FAIL rst_mid_out: got valid=%b m=%0d expected 0/0", out_valid, out_m);
    end
    rst_n = 1'b1;
    seen  = 0;
    for (int k = 0; k < 70; k++) begin
      tick();
      if (out_valid !== 1'b0) seen = seen + 1;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL rst_mid_quiet: got %0d valid cycles expected 0", seen);
    end
    t0 = cyc;
    drive_burst(4'd5, 4'd7, 8'd5, c_b, 8);
    capture(1'b0, first, got, nv);
    n_cmp++;
    if (first - t0 !== 73 || nv !== 8) begin
      n_bad++;
      $display("FAIL rst_mid_timing: got latency=%0d valid=%0d expected 73/8", first - t0, nv);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (got[k] !== m_b[k]) begin
        n_bad++;
        $display("FAIL rst_mid_m[%0d]: got %0d expected %0d", k, got[k], m_b[k]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int first_a, last_a, first_b, nv_a, nv_b;
    vec_t got_a, got_b;
    drive_burst(4'd3, 4'd11, 8'd3, c_a, 8);
    capture(1'b0, first_a, got_a, nv_a);
    last_a = cyc;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_gap_valid: got %b expected 0", out_valid);
    end
    drive_burst(4'd5, 4'd7, 8'd5, c_b, 8);
    capture(1'b0, first_b, got_b, nv_b);
    n_cmp++;
    if (nv_a !== 8 || got_a[7] !== 8'd4) begin
      n_bad++;
      $display("FAIL b2b_first: got valid=%0d m7=%0d expected 8/4", nv_a, got_a[7]);
    end
    n_cmp++;
    if (first_b - last_a !== 74) begin
      n_bad++;
      $display("FAIL b2b_spacing: got %0d expected 74", first_b - last_a);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (got_b[k] !== m_b[k]) begin
        n_bad++;
        $display("FAIL b2b_m[%0d]: got %0d expected %0d", k, got_b[k], m_b[k]);
      end
    end
    tick();
  endtask

  task automatic test_ignore_pulses();
    int t0, first, nv;
    vec_t got;
    t0 = cyc;
    drive_burst(4'd5, 4'd7, 8'd5, c_b, 8);
    capture(1'b1, first, got, nv);
    n_cmp++;
    if (first - t0 !== 73 || nv !== 8) begin
      n_bad++;
      $display("FAIL pulse_timing: got latency=%0d valid=%0d expected 73/8", first - t0, nv);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (got[k] !== m_b[k]) begin
        n_bad++;
        $display("FAIL pulse_m[%0d]: got %0d expected %0d", k, got[k], m_b[k]);
      end
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL pulse_after: got %b expected 0", out_valid);
    end
    // A burst after the pulsed run must still decode normally.
    for (int k = 0; k < 3; k++) tick();
    test_single_key();
  endtask

  initial begin
    cyc      = 0;
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_p     = 4'd0;
    in_q     = 4'd0;
    in_e     = 8'd0;
    in_c     = 8'd0;
    test_reset();
    test_single_key();
    test_mixed_cipher();
    test_abort();
    test_reset_mid_exp();
    test_back_to_back();
    test_ignore_pulses();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
